// File: rtl/div_unit_pkg.sv
// Shared definitions for the iterative divider: FSM state codes and counter width.
package div_unit_pkg;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_RUN  = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

  localparam int DIV_CNT_W = 5;

endpackage

// File: rtl/div_unit_step.sv
// One radix-2 restoring division iteration (purely combinational).
// The dividend is shifted out of quo MSB-first while quotient bits shift in at the LSB.
module div_unit_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] quo_next
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // Trial subtract; the extra top bit of diff is the borrow that selects restore.
  always_comb begin
    shifted  = {rem, quo[WIDTH-1]};
    diff     = shifted - {1'b0, divisor};
    quo_next = {quo[WIDTH-2:0], ~diff[WIDTH]};
    rem_next = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
  end

endmodule

// File: rtl/div_unit.sv
// Iterative restoring divider for MIPS DIV/DIVU feeding the HI/LO register.
// Optional build macro: DIV_ZERO_FAST_EN -- a zero divisor skips the iterations
// and finishes in the cycle after start.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             signed_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             annul_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam logic [WIDTH-1:0] ALL_ONES = '1;

  div_state_e           state, state_next;
  logic [DIV_CNT_W-1:0] cnt;
  logic [WIDTH-1:0]     rem, quo, dvs, a_raw;
  logic [WIDTH-1:0]     rem_next, quo_next;
  logic [WIDTH-1:0]     res_hi, res_lo;
  logic [WIDTH-1:0]     hi_q, lo_q;
  logic                 sign_q, sign_r, div_zero;
  logic                 accept, last;

  function automatic logic [WIDTH-1:0] abs_if(input logic en, input logic [WIDTH-1:0] v);
    return (en && v[WIDTH-1]) ? -v : v;
  endfunction

  function automatic logic [WIDTH-1:0] neg_if(input logic en, input logic [WIDTH-1:0] v);
    return en ? -v : v;
  endfunction

  assign accept = (state == DIV_IDLE) && start_i && !annul_i;
  assign last   = (cnt == DIV_CNT_W'(WIDTH - 1));

  div_unit_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem),
    .quo      (quo),
    .divisor  (dvs),
    .rem_next (rem_next),
    .quo_next (quo_next)
  );

  // Next-state and strobe decode; annul wins over every transition.
  always_comb begin
    state_next = state;
    busy_o     = (state == DIV_RUN);
    done_o     = (state == DIV_DONE) && !annul_i;
    unique case (state)
      DIV_IDLE: begin
        if (accept) begin
`ifdef DIV_ZERO_FAST_EN
          state_next = (b_i == '0) ? DIV_DONE : DIV_RUN;
`else
          state_next = DIV_RUN;
`endif
        end
      end
      DIV_RUN: begin
        if (annul_i)   state_next = DIV_IDLE;
        else if (last) state_next = DIV_DONE;
      end
      DIV_DONE: state_next = DIV_IDLE;
      default:  state_next = DIV_IDLE;
    endcase
  end

  // Control state: FSM, iteration counter and the architecturally visible HI/LO hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= DIV_IDLE;
      cnt   <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
    end else begin
      state <= state_next;
      if (accept)                 cnt <= '0;
      else if (state == DIV_RUN)  cnt <= cnt + 1'b1;
      if (done_o) begin
        hi_q <= res_hi;
        lo_q <= res_lo;
      end
    end
  end

  // Operand capture and per-cycle restoring iteration.
  always_ff @(posedge clk) begin
    if (accept) begin
      rem      <= '0;
      quo      <= abs_if(signed_i, a_i);
      dvs      <= abs_if(signed_i, b_i);
      a_raw    <= a_i;
      sign_q   <= signed_i & (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
      sign_r   <= signed_i & a_i[WIDTH-1];
      div_zero <= (b_i == '0);
    end else if (state == DIV_RUN) begin
      rem <= rem_next;
      quo <= quo_next;
    end
  end

  // Sign-corrected result registered on entry to DONE so it is ready with done_o.
  always_ff @(posedge clk) begin
`ifdef DIV_ZERO_FAST_EN
    if (accept && b_i == '0) begin
      res_hi <= a_i;
      res_lo <= ALL_ONES;
    end else
`endif
    if (state == DIV_RUN && last) begin
      res_hi <= div_zero ? a_raw    : neg_if(sign_r, rem_next);
      res_lo <= div_zero ? ALL_ONES : neg_if(sign_q, quo_next);
    end
  end

  // The DONE cycle presents the fresh result; otherwise the last delivered one holds.
  assign hi_o = done_o ? res_hi : hi_q;
  assign lo_o = done_o ? res_lo : lo_q;

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: stimulus pushes expected HI/LO, a monitor pops on done_o.
// Honours DIV_ZERO_FAST_EN for the divide-by-zero latency.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        signed_in = 1'b0;
  logic [31:0] a_in = '0;
  logic [31:0] b_in = '0;
  logic        annul = 1'b0;
  logic        busy, done;
  logic [31:0] hi, lo;

  int errors = 0;
  int checks = 0;
  logic [63:0] exp_q[$];

`ifdef DIV_ZERO_FAST_EN
  localparam int ZLAT  = 1;
  localparam int ZBUSY = 0;
`else
  localparam int ZLAT  = 33;
  localparam int ZBUSY = 32;
`endif

  div_unit #(.WIDTH(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .start_i  (start),
    .signed_i (signed_in),
    .a_i      (a_in),
    .b_i      (b_in),
    .annul_i  (annul),
    .busy_o   (busy),
    .done_o   (done),
    .hi_o     (hi),
    .lo_o     (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every done_o must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && done === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        check("hi", hi, e[63:32]);
        check("lo", lo, e[31:0]);
      end
    end
  end

  task automatic start_op(input logic sg, input logic [31:0] a, input logic [31:0] b);
    @(posedge clk); #1;
    start = 1'b1; signed_in = sg; a_in = a; b_in = b;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic run_op(input string name, input logic sg, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] hi_e, input logic [31:0] lo_e,
                        input int lat_e, input int busy_e, input bit stray);
    int cyc;
    int busy_n;
    bit seen;
    cyc = 0; busy_n = 0; seen = 1'b0;
    exp_q.push_back({hi_e, lo_e});
    start_op(sg, a, b);
    while (!seen && cyc < 80) begin
      @(negedge clk);
      cyc++;
      if (busy === 1'b1) busy_n++;
      if (done === 1'b1) seen = 1'b1;
      if (stray && cyc == 5)  begin start = 1'b1; a_in = 32'd99; b_in = 32'd3; end
      if (stray && cyc == 6)  start = 1'b0;
    end
    if (!seen) begin
      check({name, "_timeout"}, 32'd0, 32'd1);
    end else begin
      check({name, "_latency"}, 32'(cyc), 32'(lat_e));
      check({name, "_busy_cycles"}, 32'(busy_n), 32'(busy_e));
      if (stray) begin
        start = 1'b1; a_in = 32'd50; b_in = 32'd5;
        @(posedge clk); #1;
        start = 1'b0;
      end
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    rst = 1'b0;

    run_op("divu_100_7", 1'b0, 32'd100, 32'd7, 32'd2, 32'd14, 33, 32, 1'b0);
    run_op("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 33, 32, 1'b0);
    run_op("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 33, 32, 1'b0);
    run_op("div_m100_m7", 1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd14, 33, 32, 1'b0);
    run_op("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 33, 32, 1'b0);
    run_op("divu_max_16", 1'b0, 32'hFFFF_FFFF, 32'h10, 32'hF, 32'h0FFF_FFFF, 33, 32, 1'b0);
    run_op("divu_max_1", 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'hFFFF_FFFF, 33, 32, 1'b0);
    run_op("divu_by0", 1'b0, 32'h1234, 32'd0, 32'h1234, 32'hFFFF_FFFF, ZLAT, ZBUSY, 1'b0);
    run_op("div_by0", 1'b1, 32'hFFFF_FFF0, 32'd0, 32'hFFFF_FFF0, 32'hFFFF_FFFF, ZLAT, ZBUSY, 1'b0);

    // Annul mid-operation: no result, outputs hold the previous one.
    start_op(1'b0, 32'd1000, 32'd3);
    repeat (9) @(posedge clk);
    #1;
    check("annul_busy_before", 32'(busy), 32'd1);
    annul = 1'b1;
    @(posedge clk); #1;
    annul = 1'b0;
    check("annul_busy_after", 32'(busy), 32'd0);
    check("annul_hi_hold", hi, 32'hFFFF_FFF0);
    check("annul_lo_hold", lo, 32'hFFFF_FFFF);
    repeat (40) @(posedge clk);
    run_op("after_annul", 1'b0, 32'd1000, 32'd3, 32'd1, 32'd333, 33, 32, 1'b0);

    // Annul coincident with start in IDLE blocks the start.
    @(posedge clk); #1;
    start = 1'b1; annul = 1'b1; a_in = 32'd9; b_in = 32'd2;
    @(posedge clk); #1;
    start = 1'b0; annul = 1'b0;
    check("annul_blocks_start", 32'(busy), 32'd0);

    // Reset mid-operation clears everything.
    start_op(1'b0, 32'd77, 32'd5);
    repeat (19) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_hi", hi, 32'd0);
    check("midrst_lo", lo, 32'd0);
    repeat (40) @(posedge clk);

    // Stray starts in RUN and in the done cycle are ignored.
    run_op("stray_starts", 1'b0, 32'd77, 32'd5, 32'd2, 32'd15, 33, 32, 1'b1);
    repeat (40) @(posedge clk);
    #1;
    check("idle_after_stray", 32'(busy), 32'd0);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
